// File: rtl/psum_pkg.sv
// Shared encodings and the saturating lane add for the partial-sum memory.
package psum_pkg;

  typedef enum logic {MODE_OVR = 1'b0, MODE_ACC = 1'b1} mode_t;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // Operands are sign-extended to 64 bits; w is the lane width to saturate to (w <= 32).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Lane-parallel saturating add (or pass-through of b) with optional per-lane ReLU.
module psum_sat_add
  import psum_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16
) (
  input  logic [psum_bw*col-1:0] a,
  input  logic [psum_bw*col-1:0] b,
  input  logic                   acc,
  input  logic                   relu,
  output logic [psum_bw*col-1:0] y
);

  function automatic logic signed [psum_bw-1:0] lane_add(input logic signed [psum_bw-1:0] x,
                                                         input logic signed [psum_bw-1:0] z);
    logic signed [63:0] s;
    s = sat_add(64'(x), 64'(z), psum_bw);
    return s[psum_bw-1:0];
  endfunction

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic signed [psum_bw-1:0] la, lb, r;
    assign la = a[i*psum_bw +: psum_bw];
    assign lb = b[i*psum_bw +: psum_bw];
    assign r  = acc ? lane_add(la, lb) : lb;
    assign y[i*psum_bw +: psum_bw] = (relu && r[psum_bw-1]) ? '0 : r;
  end

endmodule

// File: rtl/psum_accum_mem.sv
// Partial-sum memory: 2-stage read-modify-write accumulate with S2 forwarding,
// single-cycle reads with optional ReLU, and a hardware clear sweep.
module psum_accum_mem
  import psum_pkg::*;
#(
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int addr_width = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [addr_width-1:0]  in_addr,
  input  logic [psum_bw*col-1:0] in_data,
  input  logic                   rd_req,
  output logic                   rd_ready,
  input  logic [addr_width-1:0]  rd_addr,
  input  logic                   rd_relu,
  output logic                   rd_valid,
  output logic [psum_bw*col-1:0] rd_data,
  input  logic                   clr_start,
  output logic                   busy
);

  localparam int W = psum_bw * col;
  localparam logic [addr_width-1:0] LAST = '1;
  localparam logic [addr_width-1:0] ONE  = 1;

  logic [W-1:0] mem [0:(2**addr_width)-1];

  state_t                 state, state_nxt;
  logic [addr_width-1:0]  clr_cnt;
  logic                   clr_we;
  logic                   wr_acc, rd_acc;

  logic                   vld_p1;
  logic [addr_width-1:0]  addr_p1;
  logic                   mode_p1;
  logic [W-1:0]           data_p1, old_p1;
  logic [W-1:0]           s2_res;

  logic [addr_width-1:0]  raddr;
  logic [W-1:0]           fwd, rd_next;
  logic                   we;
  logic [addr_width-1:0]  waddr;
  logic [W-1:0]           wdata;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    in_ready  = 1'b0;
    rd_ready  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      IDLE: begin
        rd_ready = 1'b1;
        in_ready = ~rd_req;
        if (clr_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        // A write still in S2 owns the write port; the sweep waits one cycle.
        clr_we = ~vld_p1;
        if (clr_we && clr_cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_acc = in_valid & in_ready;
  assign rd_acc = rd_req & rd_ready;

  // Reads and write-accepts are exclusive, so one array read port serves both.
  assign raddr = rd_req ? rd_addr : in_addr;
  assign fwd   = (vld_p1 && addr_p1 == raddr) ? s2_res : mem[raddr];

  for (genvar i = 0; i < col; i++) begin : g_relu
    assign rd_next[i*psum_bw +: psum_bw] =
      (rd_relu && fwd[i*psum_bw+psum_bw-1]) ? '0 : fwd[i*psum_bw +: psum_bw];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      vld_p1   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) clr_cnt <= '0;
      else if (clr_we)   clr_cnt <= clr_cnt + ONE;
      vld_p1   <= wr_acc;
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_next;
    end
  end

  // ---- S1 -> S2 boundary: capture request and (forwarded) old contents ----
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      addr_p1 <= in_addr;
      mode_p1 <= in_mode;
      data_p1 <= in_data;
      old_p1  <= fwd;
    end
  end

  psum_sat_add #(.col(col), .psum_bw(psum_bw)) u_add (
    .a    (old_p1),
    .b    (data_p1),
    .acc  (mode_p1 == MODE_ACC),
    .relu (1'b0),
    .y    (s2_res)
  );

  // ---- S2 -> array boundary ----
  assign we    = vld_p1 | clr_we;
  assign waddr = vld_p1 ? addr_p1 : clr_cnt;
  assign wdata = vld_p1 ? s2_res : '0;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule
